cpu_board_display: RTL
======================

# cpu_board_display

Board-side companion to the multi-cycle CPU top. It consumes the CPU's four 16-bit debug words (PC, RS, RT, ALU/DB) and shows the switch-selected word on a 4-digit multiplexed seven-segment display. It also turns a raw, bouncing step pushbutton into a clean single-step clock pulse for the CPU's negative-pulse CLK input, and counts issued steps.

## Interface
Parameters:
- SCAN_DIV, 100000: CLK cycles each digit stays lit.
- DEBOUNCE_CYCLES, 1000000: consecutive synchronized samples needed to accept a button level change.
- PULSE_CYCLES, 4: CLK cycles cpu_clk is held low per step.

Ports:
- CLK  in  1  board clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- sel  in  2  display select: 0→disp_word1, 1→disp_word2, 2→disp_word3, 3→disp_word4.
- step_btn  in  1  raw pushbutton, active high, asynchronous to CLK.
- disp_word1..disp_word4  in  16 each  CPU debug words out_sign1..out_sign4.
- cpu_clk  out  1  CPU step clock; idles 1, one low pulse per accepted press.
- an  out  4  digit enables, active low; an[0] is the rightmost digit.
- seg  out  8  segments, active low, ordered {dp,g,f,e,d,c,b,a}.
- step_count  out  16  number of pulses issued; wraps 16'hFFFF→0.

## Operation
- Synchronizer: two flops (s1, s2) on step_btn.
- Debouncer: register stable and counter db_cnt.
  - If s2==stable, db_cnt←0.
  - Else if db_cnt==DEBOUNCE_CYCLES-1, stable←s2 and db_cnt←0.
  - Else db_cnt←db_cnt+1.
- Step FSM:
  - IDLE: cpu_clk=1. When stable==1, go to LOW, load pulse_cnt←0, and increment step_count.
  - LOW: cpu_clk=0. pulse_cnt increments each cycle; at pulse_cnt==PULSE_CYCLES-1 go to WAIT_REL.
  - WAIT_REL: cpu_clk=1. Return to IDLE when stable==0.
  - One pulse per press, no auto-repeat. cpu_clk is a registered output.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1.
  - On wrap, digit (2 bits) increments mod 4.
  - word_reg←selected word whenever digit==0 and div_cnt==0. A full frame therefore shows one snapshot (no tearing). A change of sel takes effect at the next frame.
- Decode:
  - an = ~(1<<digit).
  - Nibble is word_reg[4·digit+3 : 4·digit].
  - Hex table (g..a, active low): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E. Values include dp=1.
  - dp=0 (lit) only on digit 2, to separate the high and low bytes.
- an/seg are registered from (digit, word_reg), so they lag the internal state by 1 cycle.

## Timing
- Reset (Reset==0 at a rising edge) gives, next cycle:
  - cpu_clk=1, an=4'hF, seg=8'hFF, step_count=0.
  - state=IDLE, stable=0, s1=s2=0, db_cnt=pulse_cnt=div_cnt=0, digit=0, word_reg=0.
- Reset mid-pulse aborts the pulse: cpu_clk=1 the next cycle. A button still held after reset re-debounces and yields a new pulse.
- Button latency: step_btn rises before edge 1 → cpu_clk low after edge DEBOUNCE_CYCLES+3, held for exactly PULSE_CYCLES cycles.
- Release latency to re-arm: DEBOUNCE_CYCLES+2 cycles of continuous low.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES samples resets db_cnt and is ignored.
- First cycle after reset release:
  - word_reg loads the selected word.
  - an=4'b1110, seg shows nibble 0 of the old word_reg (0 → C0).
  - The correct value appears from the next cycle.
- Each digit is lit SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8, PULSE_CYCLES=4.
- Reset: hold Reset=0 for 3 cycles with step_btn=1 → cpu_clk=1, an=F, seg=FF, step_count=0 throughout.
- Display: sel=0, disp_word1=16'h1A2F, step_btn=0 → after the first frame, an cycles 1110/1101/1011/0111 every 4 cycles; seg=8E/A4/08/F9 respectively (digit 2 shows dp lit).
- Clean press: step_btn rises and stays high 40 cycles → cpu_clk low exactly during cycles 11–14, step_count=1, no further pulse while held.
- Bounce: step_btn toggles every 3 cycles for 30 cycles, then high for 20 → exactly one 4-cycle pulse, step_count=1.
- Two presses: press 20 cycles, release 20, press 20 → two pulses, step_count=2. Separately, preload step_count=FFFF by issuing presses → the next press gives 0.
- Reset mid-pulse: assert Reset during the second low cycle → cpu_clk=1 the next cycle, step_count=0. Keep the button held → a new pulse starts 11 cycles after Reset releases, step_count=1.

Source files
------------

// File: rtl/cpu_board_display.sv
// Board-side helper for the multi-cycle CPU. It scans one selected 16-bit debug word onto a
// 4-digit seven-segment display and turns a bouncing step button into single cpu_clk pulses.
module cpu_board_display #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PULSE_CYCLES    = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  sel,
    input  logic        step_btn,
    input  logic [15:0] disp_word1,
    input  logic [15:0] disp_word2,
    input  logic [15:0] disp_word3,
    input  logic [15:0] disp_word4,
    output logic        cpu_clk,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [15:0] step_count
);

    localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PcW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PcW-1:0]  PcMax  = PcW'(PULSE_CYCLES - 1);
    localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLow, StWaitRel} state_t;

    logic           s1_q, s2_q, stable_q;
    logic [DbW-1:0] db_cnt_q;

    state_t         state_q, state_d;
    logic [PcW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic           count_inc;

    logic [DivW-1:0] div_cnt_q;
    logic [1:0]      digit_q;
    logic [15:0]     word_reg_q, word_sel;
    logic [3:0]      nibble;
    logic [7:0]      hex_seg;

    // Button synchronizer and debouncer
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            s1_q <= step_btn;
            s2_q <= s1_q;
            if (s2_q == stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbMax) begin
                stable_q <= s2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DbW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        count_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (stable_q) begin
                    state_d     = StLow;
                    pulse_cnt_d = '0;
                    count_inc   = 1'b1;
                end
            end
            StLow: begin
                pulse_cnt_d = pulse_cnt_q + PcW'(1);
                if (pulse_cnt_q == PcMax) state_d = StWaitRel;
            end
            StWaitRel: begin
                if (!stable_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // cpu_clk is registered from the next state so the low phase lines up with StLow
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q     <= StIdle;
            pulse_cnt_q <= '0;
            cpu_clk     <= 1'b1;
            step_count  <= '0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            cpu_clk     <= (state_d != StLow);
            step_count  <= step_count + 16'(count_inc);
        end
    end

    always_comb begin
        word_sel = disp_word1;
        unique case (sel)
            2'd0: word_sel = disp_word1;
            2'd1: word_sel = disp_word2;
            2'd2: word_sel = disp_word3;
            2'd3: word_sel = disp_word4;
            default: word_sel = disp_word1;
        endcase
    end

    assign nibble = word_reg_q[{digit_q, 2'b00} +: 4];

    always_comb begin
        hex_seg = 8'hFF;
        unique case (nibble)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            4'hF: hex_seg = 8'h8E;
            default: hex_seg = 8'hFF;
        endcase
    end

    // Snapshot the word only at frame start so a frame never mixes two values
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            div_cnt_q  <= '0;
            digit_q    <= '0;
            word_reg_q <= '0;
            an         <= 4'hF;
            seg        <= 8'hFF;
        end else begin
            if (div_cnt_q == DivMax) begin
                div_cnt_q <= '0;
                digit_q   <= digit_q + 2'd1;
            end else begin
                div_cnt_q <= div_cnt_q + DivW'(1);
            end
            if (digit_q == 2'd0 && div_cnt_q == '0) word_reg_q <= word_sel;
            an  <= ~(4'b0001 << digit_q);
            seg <= {digit_q != 2'd2, hex_seg[6:0]};
        end
    end

endmodule
